// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter/sequencer sharing one gated active-low SR latch.
// Optional readback compare: define SR_LATCH_ARB_VERIFY_EN.
// Handshake: a requester holds req high; the arbiter latches its command at the grant
// edge, holds gnt for the whole operation and pulses done for one cycle at the end.
module sr_latch_arbiter #(
  parameter int NREQ       = 4,
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] cmd_s,
  input  logic [NREQ-1:0] cmd_r,
  output logic [NREQ-1:0] gnt,
  output logic            done,
  output logic            err,
  output logic            mismatch,
  output logic            rd_q,
  output logic            s,
  output logic            r,
  output logic            en,
  input  logic            q,
  output logic [2:0]      dbg_state
);
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt, w_idx;
  logic [NREQ-1:0] r_gnt;
  logic [1:0]      r_op, w_op_nxt;   // {set, reset} command of the granted requester
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_s, r_r, r_en;
  logic            w_found, w_drive, w_s_nxt, w_r_nxt, w_en_nxt;
  int              w_cand;

  // Ascending search from r_ptr with wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand[PW-1:0];
      end
    end
    w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_op_nxt    = {cmd_s[w_idx], cmd_r[w_idx]};
          w_state_nxt = (cmd_s[w_idx] ^ cmd_r[w_idx]) ? ST_SETUP : ST_DONE;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_PULSE;
        w_cnt_nxt   = '0;
      end
      ST_PULSE: begin
        if (r_cnt == CW'(EN_CYCLES - 1)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == CW'(GAP_CYCLES - 1)) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch lines are registered from the next state so they never glitch;
  // s/r only move on edges where en is 0 on both sides.
  always_comb begin
    w_drive  = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_PULSE) ||
               (w_state_nxt == ST_HOLD);
    w_s_nxt  = ~(w_drive & w_op_nxt[1]);
    w_r_nxt  = ~(w_drive & w_op_nxt[0]);
    w_en_nxt = (w_state_nxt == ST_PULSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_op    <= 2'b00;
      r_cnt   <= '0;
      r_s     <= 1'b1;
      r_r     <= 1'b1;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_en    <= w_en_nxt;
      if (r_state == ST_IDLE && w_found) begin
        r_gnt <= NREQ'(1) << w_idx;
        r_ptr <= w_ptr_nxt;
      end else if (r_state == ST_DONE) begin
        r_gnt <= '0;
      end
    end
  end

  assign gnt       = r_gnt;
  assign s         = r_s;
  assign r         = r_r;
  assign en        = r_en;
  assign done      = (r_state == ST_DONE);
  assign err       = done & r_op[1] & r_op[0];
  assign rd_q      = done & q;
  assign dbg_state = r_state;

`ifdef SR_LATCH_ARB_VERIFY_EN
  // Written value equals the set bit of the op for SET/RESET.
  assign mismatch = done & (r_op[1] ^ r_op[0]) & (q != r_op[1]);
`else
  assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Directed bench for sr_latch_arbiter with a behavioural gated SR latch on q.
module tb_sr_latch_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, cmd_s, cmd_r, gnt;
  logic       done, err, mismatch, rd_q, s, r, en, q;
  logic [2:0] dbg_state;
  logic       latch_q;
  logic       force_q0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  sr_latch_arbiter #(.NREQ(4), .EN_CYCLES(2), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r),
    .gnt(gnt), .done(done), .err(err), .mismatch(mismatch), .rd_q(rd_q),
    .s(s), .r(r), .en(en), .q(q), .dbg_state(dbg_state)
  );

  // Active-low gated SR latch: transparent while en is high.
  always_latch begin
    if (en) begin
      if (!s && r)      latch_q <= 1'b1;
      else if (s && !r) latch_q <= 1'b0;
    end
  end
  assign q = force_q0 ? 1'b0 : latch_q;

  // Latch-safety invariants, checked every cycle outside reset edges.
  logic p_en = 1'b0, p_s = 1'b1, p_r = 1'b1, rs_edge;
  always begin
    @(posedge clk);
    rs_edge = rst;
    #1;
    n_tests++;
    if (en && !s && !r) begin
      n_fail++;
      $display("FAIL inv_en_sr0: en=%b s=%b r=%b required no en with s=r=0", en, s, r);
    end
    if (!rs_edge && rs_edge !== 1'bx) begin
      n_tests++;
      if (en !== p_en && (s !== p_s || r !== p_r)) begin
        n_fail++;
        $display("FAIL inv_sr_en_edge: en %b->%b s %b->%b r %b->%b required s/r stable", p_en, en, p_s, s, p_r, r);
      end
    end
    p_en = en; p_s = s; p_r = r;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; cmd_s = '0; cmd_r = '0; force_q0 = 1'b0;
    tick(); tick();
    n_tests++;
    if (gnt !== 4'b0000 || done !== 1'b0 || err !== 1'b0 || mismatch !== 1'b0 || rd_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b mm=%b rd_q=%b required all 0", gnt, done, err, mismatch, rd_q);
    end
    n_tests++;
    if ({s, r, en} !== 3'b110 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_latch_lines: s r en=%b state=%0d required 110 state 0", {s, r, en}, dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_set();
    logic [3:0] exp_seq [1:5];   // {done, en, s, r} per cycle after grant edge
    exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0101; exp_seq[3] = 4'b0101;
    exp_seq[4] = 4'b0001; exp_seq[5] = 4'b1011;
    req = 4'b0010; cmd_s = 4'b0010; cmd_r = 4'b0000;
    tick();
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL set_gnt: got %b required 0010", gnt);
    end
    req = '0; cmd_s = '0;
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) tick();
      n_tests++;
      if ({done, en, s, r} !== exp_seq[c]) begin
        n_fail++;
        $display("FAIL set_seq_c%0d: done en s r=%b required %b", c, {done, en, s, r}, exp_seq[c]);
      end
    end
    n_tests++;
    if (rd_q !== 1'b1 || mismatch !== 1'b0 || gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL set_done: rd_q=%b mm=%b gnt=%b required 1 0 0010", rd_q, mismatch, gnt);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL set_release: gnt=%b done=%b required 0000 0", gnt, done);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; cmd_s = 4'b0000; cmd_r = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << (n % 4);
      tick();
      n_tests++;
      if (gnt !== exp_g) begin
        n_fail++;
        $display("FAIL rr_gnt_%0d: got %b required %b", n, gnt, exp_g);
      end
      tick(); tick(); tick(); tick();
      n_tests++;
      if (done !== 1'b1 || rd_q !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_done_%0d: done=%b rd_q=%b err=%b required 1 0 0", n, done, rd_q, err);
      end
      tick();
      n_tests++;
      if (gnt !== 4'b0000 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle_%0d: gnt=%b done=%b required 0000 0", n, gnt, done);
      end
    end
    req = '0; cmd_r = '0;
  endtask

  task automatic test_illegal();
    req = 4'b0100; cmd_s = 4'b0100; cmd_r = 4'b0100;
    tick();
    req = '0; cmd_s = '0; cmd_r = '0;
    n_tests++;
    if (gnt !== 4'b0100 || done !== 1'b1 || err !== 1'b1 || mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_done: gnt=%b done=%b err=%b mm=%b required 0100 1 1 0", gnt, done, err, mismatch);
    end
    n_tests++;
    if ({s, r, en} !== 3'b110) begin
      n_fail++;
      $display("FAIL illegal_lines: s r en=%b required 110", {s, r, en});
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || done !== 1'b0 || err !== 1'b0 || {s, r, en} !== 3'b110) begin
      n_fail++;
      $display("FAIL illegal_after: gnt=%b done=%b err=%b s r en=%b required 0000 0 0 110", gnt, done, err, {s, r, en});
    end
  endtask

  task automatic test_read_after_set();
    req = 4'b0001; cmd_s = 4'b0001; cmd_r = 4'b0000;
    tick();
    req = '0; cmd_s = '0;
    tick(); tick(); tick(); tick();
    n_tests++;
    if (done !== 1'b1 || rd_q !== 1'b1) begin
      n_fail++;
      $display("FAIL read_pre_set: done=%b rd_q=%b required 1 1", done, rd_q);
    end
    tick();
    req = 4'b0001;
    tick();
    req = '0;
    n_tests++;
    if (gnt !== 4'b0001 || done !== 1'b1 || rd_q !== 1'b1 || en !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL read_done: gnt=%b done=%b rd_q=%b en=%b err=%b required 0001 1 1 0 0", gnt, done, rd_q, en, err);
    end
    tick();
  endtask

  task automatic test_mismatch();
    logic exp_mm;
`ifdef SR_LATCH_ARB_VERIFY_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    force_q0 = 1'b1;
    req = 4'b0010; cmd_s = 4'b0010; cmd_r = 4'b0000;
    tick();
    req = '0; cmd_s = '0;
    tick(); tick(); tick(); tick();
    n_tests++;
    if (done !== 1'b1 || mismatch !== exp_mm || rd_q !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_done: done=%b mm=%b rd_q=%b required 1 %b 0", done, mismatch, rd_q, exp_mm);
    end
    tick();
    force_q0 = 1'b0;
  endtask

  task automatic test_rst_mid();
    req = 4'b0100; cmd_s = 4'b0100; cmd_r = 4'b0000;
    tick();
    req = '0; cmd_s = '0;
    tick();
    n_tests++;
    if (en !== 1'b1 || dbg_state !== 3'd2) begin
      n_fail++;
      $display("FAIL rstmid_pulse: en=%b state=%0d required 1 2", en, dbg_state);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({s, r, en} !== 3'b110 || gnt !== 4'b0000 || done !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL rstmid_forced: s r en=%b gnt=%b done=%b state=%0d required 110 0000 0 0", {s, r, en}, gnt, done, dbg_state);
    end
    rst = 1'b0;
    req = 4'b1000; cmd_s = 4'b0000; cmd_r = 4'b1000;
    tick();
    req = '0; cmd_r = '0;
    n_tests++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL rstmid_regrant: gnt=%b required 1000", gnt);
    end
    tick(); tick(); tick(); tick();
    n_tests++;
    if (done !== 1'b1 || rd_q !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_done: done=%b rd_q=%b required 1 0", done, rd_q);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_set();
    test_round_robin();
    test_illegal();
    test_read_after_set();
    test_mismatch();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end
endmodule
